// File: rtl/eclk_bus_cycle.sv
// 6800-style synchronous peripheral cycle responder for the CIA space.
// It aligns CPU requests to the 10-phase E period and drives VMA, E, strobes and DTACK.
module eclk_bus_cycle #(
    parameter int SYNC_PHASE = 2
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic [9:0] eclk,
    input  logic       _as,
    input  logic       _vpa,
    input  logic       rw,
    output logic       e,
    output logic       _vma,
    output logic       _dtack,
    output logic       sel,
    output logic       rd_strobe,
    output logic       wr_strobe,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_VMA,
        S_ACCESS,
        S_TERM
    } state_t;

    state_t state_q, state_d;
    logic   rw_q, rw_d;
    logic   e_q, e_d;
    logic   vma_n_q, vma_n_d;
    logic   dtack_n_q, dtack_n_d;
    logic   sel_q, sel_d;
    logic   rd_q, rd_d;
    logic   wr_q, wr_d;
    logic   busy_q, busy_d;
    logic   running;

    // An all-zero eclk means the generator is stopped: everything freezes.
    assign running = |eclk;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q   <= S_IDLE;
            rw_q      <= 1'b1;
            e_q       <= 1'b0;
            vma_n_q   <= 1'b1;
            dtack_n_q <= 1'b1;
            sel_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            e_q       <= e_d;
            vma_n_q   <= vma_n_d;
            dtack_n_q <= dtack_n_d;
            sel_q     <= sel_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
        end
    end

    // Aborts are tested before phase strobes so they win on the same edge.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        if (running) begin
            case (state_q)
                S_IDLE: begin
                    if (!_as && !_vpa) begin
                        state_d = S_SYNC;
                        rw_d    = rw;
                    end
                end
                S_SYNC: begin
                    if (_as || _vpa)            state_d = S_IDLE;
                    else if (eclk[SYNC_PHASE])  state_d = S_VMA;
                end
                S_VMA: begin
                    if (_as)          state_d = S_IDLE;
                    else if (eclk[5]) state_d = S_ACCESS;
                end
                S_ACCESS: begin
                    if (_as)          state_d = S_IDLE;
                    else if (eclk[9]) state_d = S_TERM;
                end
                S_TERM: begin
                    if (_as) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output registers are derived from the transition being taken this edge.
    always_comb begin
        e_d       = running ? (|eclk[8:5]) : e_q;
        vma_n_d   = !(state_d inside {S_VMA, S_ACCESS, S_TERM});
        dtack_n_d = (state_d != S_TERM);
        sel_d     = (state_q == S_VMA) && (state_d == S_ACCESS);
        rd_d      = (state_q == S_ACCESS) && (state_d == S_ACCESS) && eclk[8] && rw_q;
        wr_d      = (state_q == S_ACCESS) && (state_d == S_ACCESS) && eclk[8] && !rw_q;
        busy_d    = (state_d != S_IDLE);
    end

    assign e         = e_q;
    assign _vma      = vma_n_q;
    assign _dtack    = dtack_n_q;
    assign sel       = sel_q;
    assign rd_strobe = rd_q;
    assign wr_strobe = wr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_eclk_bus_cycle.sv
// Scoreboard bench for eclk_bus_cycle: a cycle model pushes expected outputs per edge,
// which are popped and compared after the edge, plus directed pulse/latency checks.
module tb_eclk_bus_cycle;
  localparam int SP = 2;
  localparam int M_IDLE = 0, M_SYNC = 1, M_VMA = 2, M_ACC = 3, M_TERM = 4;

  logic       clk = 1'b0;
  logic       _reset = 1'b1;
  logic [9:0] eclk = 10'b1;
  logic       _as = 1'b1, _vpa = 1'b1, rw = 1'b1;
  logic       e, _vma, _dtack, sel, rd_strobe, wr_strobe, busy;

  eclk_bus_cycle #(.SYNC_PHASE(SP)) dut (
    .clk(clk), ._reset(_reset), .eclk(eclk), ._as(_as), ._vpa(_vpa), .rw(rw),
    .e(e), ._vma(_vma), ._dtack(_dtack), .sel(sel), .rd_strobe(rd_strobe),
    .wr_strobe(wr_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic e, vma_n, dtack_n, sel, rd, wr, busy;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, cyc = 0, ph = 0;
  bit run_e = 1'b1;
  int sel_cnt = 0, rd_cnt = 0, wr_cnt = 0, e_hi_cnt = 0, dtack_cyc = -1, req_cyc = 0;

  int   m_st;
  logic m_rw, m_e, m_vma, m_dtack, m_sel, m_rd, m_wr, m_busy;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_rw = 1'b1; m_e = 1'b0; m_vma = 1'b1; m_dtack = 1'b1;
    m_sel = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_abort();
    m_st = M_IDLE; m_vma = 1'b1; m_dtack = 1'b1;
  endtask

  task automatic model_edge(input logic [9:0] ec, input logic as_n, input logic vpa_n, input logic rw_i);
    m_sel = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
    if (ec != 10'b0) begin
      m_e = ec[5] | ec[6] | ec[7] | ec[8];
      case (m_st)
        M_IDLE: if (!as_n && !vpa_n) begin m_rw = rw_i; m_st = M_SYNC; end
        M_SYNC: begin
          if (as_n || vpa_n) model_abort();
          else if (ec[SP]) begin m_vma = 1'b0; m_st = M_VMA; end
        end
        M_VMA: begin
          if (as_n) model_abort();
          else if (ec[5]) begin m_sel = 1'b1; m_st = M_ACC; end
        end
        M_ACC: begin
          if (as_n) model_abort();
          else begin
            if (ec[8]) begin
              if (m_rw) m_rd = 1'b1;
              else m_wr = 1'b1;
            end
            if (ec[9]) begin m_dtack = 1'b0; m_st = M_TERM; end
          end
        end
        default: if (as_n) model_abort();
      endcase
    end
    m_busy = (m_st != M_IDLE);
  endtask

  task automatic tick();
    exp_t x;
    if (!_reset) model_reset();
    else model_edge(eclk, _as, _vpa, rw);
    x.e = m_e; x.vma_n = m_vma; x.dtack_n = m_dtack; x.sel = m_sel;
    x.rd = m_rd; x.wr = m_wr; x.busy = m_busy;
    sb.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
    x = sb.pop_front();
    chk("e", 32'(e), 32'(x.e));
    chk("vma_n", 32'(_vma), 32'(x.vma_n));
    chk("dtack_n", 32'(_dtack), 32'(x.dtack_n));
    chk("sel", 32'(sel), 32'(x.sel));
    chk("rd_strobe", 32'(rd_strobe), 32'(x.rd));
    chk("wr_strobe", 32'(wr_strobe), 32'(x.wr));
    chk("busy", 32'(busy), 32'(x.busy));
    sel_cnt  += int'(sel);
    rd_cnt   += int'(rd_strobe);
    wr_cnt   += int'(wr_strobe);
    e_hi_cnt += int'(e);
    if (_dtack === 1'b0 && dtack_cyc < 0) dtack_cyc = cyc;
    if (run_e) begin
      ph = (ph + 1) % 10;
      eclk = 10'b1 << ph;
    end
  endtask

  task automatic run_until(input int p);
    int n;
    n = 0;
    while (ph != p && n < 20) begin
      tick();
      n++;
    end
    if (ph != p) chk("run_until_timeout", 32'(ph), 32'(p));
  endtask

  task automatic clr_cnt();
    sel_cnt = 0; rd_cnt = 0; wr_cnt = 0; dtack_cyc = -1;
  endtask

  task automatic set_run(input bit r);
    run_e = r;
    eclk = r ? (10'b1 << ph) : 10'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1 _reset = 1'b0;
    #1;
    chk("rst_e", 32'(e), 32'd0);
    chk("rst_vma_n", 32'(_vma), 32'd1);
    chk("rst_dtack_n", 32'(_dtack), 32'd1);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_rd", 32'(rd_strobe), 32'd0);
    chk("rst_wr", 32'(wr_strobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    _reset = 1'b1;

    // Free-running E: 30 clks = 3 periods, 4 high clks each
    clr_cnt();
    e_hi_cnt = 0;
    repeat (30) tick();
    chk("ewave_high_cnt", 32'(e_hi_cnt), 32'd12);
    chk("ewave_sel_cnt", 32'(sel_cnt), 32'd0);
    run_until(7);
    set_run(1'b0);
    repeat (4) tick();
    chk("freeze_e", 32'(e), 32'd1);
    set_run(1'b1);

    // Read cycle, request sampled at phase 0, rw flipped after acceptance
    run_until(0);
    clr_cnt();
    _as = 1'b0; _vpa = 1'b0; rw = 1'b1;
    req_cyc = cyc;
    tick();
    rw = 1'b0;
    repeat (11) tick();
    chk("rd_dtack_latency", 32'(dtack_cyc - req_cyc), 32'd10);
    chk("rd_term_vma_n", 32'(_vma), 32'd0);
    _as = 1'b1; _vpa = 1'b1;
    tick();
    chk("rd_end_busy", 32'(busy), 32'd0);
    chk("rd_sel_cnt", 32'(sel_cnt), 32'd1);
    chk("rd_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("rd_wr_cnt", 32'(wr_cnt), 32'd0);

    // Late write request at phase 4, with a generator stall while waiting
    run_until(4);
    clr_cnt();
    _as = 1'b0; _vpa = 1'b0; rw = 1'b0;
    tick();
    set_run(1'b0);
    repeat (3) tick();
    chk("late_frz_busy", 32'(busy), 32'd1);
    set_run(1'b1);
    repeat (15) tick();
    chk("late_dtack_n", 32'(_dtack), 32'd0);
    _as = 1'b1; _vpa = 1'b1;
    tick();
    chk("late_sel_cnt", 32'(sel_cnt), 32'd1);
    chk("late_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("late_rd_cnt", 32'(rd_cnt), 32'd0);

    // Abort in VMA: _as released, sampled at phase 4
    run_until(0);
    clr_cnt();
    _as = 1'b0; _vpa = 1'b0; rw = 1'b1;
    repeat (4) tick();
    _as = 1'b1;
    tick();
    chk("ab_vma_n", 32'(_vma), 32'd1);
    chk("ab_busy", 32'(busy), 32'd0);
    _vpa = 1'b1;
    repeat (5) tick();
    chk("ab_sel_cnt", 32'(sel_cnt), 32'd0);
    chk("ab_rdwr_cnt", 32'(rd_cnt + wr_cnt), 32'd0);

    // Asynchronous reset during ACCESS at phase 7
    run_until(0);
    clr_cnt();
    _as = 1'b0; _vpa = 1'b0; rw = 1'b1;
    repeat (7) tick();
    chk("mr_pre_sel_cnt", 32'(sel_cnt), 32'd1);
    #2 _reset = 1'b0;
    #1;
    chk("arst_e", 32'(e), 32'd0);
    chk("arst_vma_n", 32'(_vma), 32'd1);
    chk("arst_dtack_n", 32'(_dtack), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    model_reset();
    clr_cnt();
    _as = 1'b1; _vpa = 1'b1;
    repeat (2) tick();
    _reset = 1'b1;
    tick();
    chk("mr_post_rd_cnt", 32'(rd_cnt), 32'd0);
    run_until(0);
    clr_cnt();
    _as = 1'b0; _vpa = 1'b0; rw = 1'b1;
    repeat (12) tick();
    chk("mr_fresh_dtack_n", 32'(_dtack), 32'd0);
    _as = 1'b1; _vpa = 1'b1;
    tick();
    chk("mr_fresh_sel_cnt", 32'(sel_cnt), 32'd1);
    chk("mr_fresh_rd_cnt", 32'(rd_cnt), 32'd1);

    // Back-to-back: read, _as high for one clk, then write
    run_until(0);
    clr_cnt();
    _as = 1'b0; _vpa = 1'b0; rw = 1'b1;
    repeat (12) tick();
    _as = 1'b1;
    tick();
    chk("b2b_gap_busy", 32'(busy), 32'd0);
    _as = 1'b0; rw = 1'b0;
    tick();
    chk("b2b_second_busy", 32'(busy), 32'd1);
    repeat (16) tick();
    chk("b2b_dtack_n", 32'(_dtack), 32'd0);
    _as = 1'b1; _vpa = 1'b1;
    tick();
    chk("b2b_sel_cnt", 32'(sel_cnt), 32'd2);
    chk("b2b_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("b2b_wr_cnt", 32'(wr_cnt), 32'd1);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
